// File: rtl/link_deserializer.sv
// Reassembles width+1-bit tokens from flit_width-bit link flits and feeds them,
// through a one-token output register, to the enqueue side of a bypass FIFO.
module link_deserializer #(
  parameter int unsigned width      = 0,
  parameter int unsigned flit_width = 8
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  LINK_VALID,
  input  logic [flit_width-1:0] LINK_DATA,
  output logic                  LINK_READY,
  input  logic                  FLUSH,
  output logic                  ENQ,
  output logic [width:0]        ENQ_VALUE,
  input  logic                  NOT_FULL
);

  localparam int unsigned TW = width + 1;
  localparam int unsigned NF = (TW + flit_width - 1) / flit_width;
  localparam int unsigned AW = NF * flit_width;
  localparam int unsigned CW = (NF > 1) ? $clog2(NF) : 1;

  logic [AW-1:0] asm_q, asm_n;
  logic [CW-1:0] cnt_q, cnt_n;
  logic [TW-1:0] out_data_q, out_data_n;
  logic          out_full_q, out_full_n;

  logic          last_c;
  logic          accept_c;
  logic [AW-1:0] cat_c;

  // Final flit may stall only while the held token cannot drain; FLUSH blocks both sides.
  assign last_c     = (cnt_q == CW'(NF - 1));
  assign LINK_READY = !FLUSH && (!last_c || !out_full_q || NOT_FULL);
  assign ENQ        = !FLUSH && out_full_q && NOT_FULL;
  assign ENQ_VALUE  = out_data_q;
  assign accept_c   = LINK_VALID && LINK_READY;

  // Completed token: the incoming flit on top of the buffered lower flits.
  always_comb begin
    cat_c = asm_q;
    cat_c[AW-1 -: flit_width] = LINK_DATA;
  end

  // Padding bits of the final flit and the never-written top slot of asm_q.
  logic unused_bits;
  assign unused_bits = ^{asm_q[AW-1 -: flit_width], cat_c};

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      asm_q      <= '0;
      cnt_q      <= '0;
      out_data_q <= '0;
      out_full_q <= 1'b0;
    end else begin
      asm_q      <= asm_n;
      cnt_q      <= cnt_n;
      out_data_q <= out_data_n;
      out_full_q <= out_full_n;
    end
  end

  // Next state of the implicit COLLECT_k / HOLD control.
  always_comb begin
    asm_n      = asm_q;
    cnt_n      = cnt_q;
    out_data_n = out_data_q;
    out_full_n = out_full_q;
    if (FLUSH) begin
      cnt_n      = '0;
      out_full_n = 1'b0;
    end else begin
      if (ENQ) begin
        out_full_n = 1'b0;
      end
      if (accept_c) begin
        if (last_c) begin
          out_data_n = cat_c[TW-1:0];
          out_full_n = 1'b1;
          cnt_n      = '0;
        end else begin
          asm_n[32'(cnt_q) * flit_width +: flit_width] = LINK_DATA;
          cnt_n = cnt_q + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_link_deserializer.sv
// Directed, table-driven bench for link_deserializer in three geometries:
// A = 16-bit token (NF=2), B = 12-bit token (NF=2, padded), C = 8-bit token (NF=1).
`timescale 1ns/1ps
module tb_link_deserializer;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        LINK_VALID = 1'b0;
  logic [7:0]  LINK_DATA = '0;
  logic        FLUSH = 1'b0;
  logic        NOT_FULL = 1'b1;

  logic        ready_a, enq_a;
  logic [15:0] val_a;
  logic        ready_b, enq_b;
  logic [11:0] val_b;
  logic        ready_c, enq_c;
  logic [7:0]  val_c;

  always #5 CLK = ~CLK;

  link_deserializer #(.width(15), .flit_width(8)) dut_a (
    .CLK(CLK), .RST_N(RST_N), .LINK_VALID(LINK_VALID), .LINK_DATA(LINK_DATA),
    .LINK_READY(ready_a), .FLUSH(FLUSH), .ENQ(enq_a), .ENQ_VALUE(val_a), .NOT_FULL(NOT_FULL));

  link_deserializer #(.width(11), .flit_width(8)) dut_b (
    .CLK(CLK), .RST_N(RST_N), .LINK_VALID(LINK_VALID), .LINK_DATA(LINK_DATA),
    .LINK_READY(ready_b), .FLUSH(FLUSH), .ENQ(enq_b), .ENQ_VALUE(val_b), .NOT_FULL(NOT_FULL));

  link_deserializer #(.width(7), .flit_width(8)) dut_c (
    .CLK(CLK), .RST_N(RST_N), .LINK_VALID(LINK_VALID), .LINK_DATA(LINK_DATA),
    .LINK_READY(ready_c), .FLUSH(FLUSH), .ENQ(enq_c), .ENQ_VALUE(val_c), .NOT_FULL(NOT_FULL));

  typedef struct {
    int          sel;
    bit          rstn;
    bit          flush;
    bit          valid;
    logic [7:0]  data;
    bit          nf;
    bit          e_ready;
    bit          e_enq;
    bit          cv;
    logic [15:0] e_val;
  } vec_t;

  vec_t vq[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic vec_t mk(int sel, bit rstn, bit flush, bit valid, logic [7:0] data,
                              bit nf, bit e_ready, bit e_enq, bit cv, logic [15:0] e_val);
    vec_t v;
    v.sel = sel; v.rstn = rstn; v.flush = flush; v.valid = valid; v.data = data;
    v.nf = nf; v.e_ready = e_ready; v.e_enq = e_enq; v.cv = cv; v.e_val = e_val;
    return v;
  endfunction

  task automatic check(string name, logic [15:0] act, logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One cycle: drive inputs, let comb outputs settle, compare, then clock.
  task automatic run_vec(vec_t v, string tag);
    logic        r, e;
    logic [15:0] d;
    RST_N      = v.rstn;
    FLUSH      = v.flush;
    LINK_VALID = v.valid;
    LINK_DATA  = v.data;
    NOT_FULL   = v.nf;
    #1;
    case (v.sel)
      0:       begin r = ready_a; e = enq_a; d = val_a; end
      1:       begin r = ready_b; e = enq_b; d = {4'h0, val_b}; end
      default: begin r = ready_c; e = enq_c; d = {8'h00, val_c}; end
    endcase
    check($sformatf("%s ready", tag), {15'd0, r}, {15'd0, v.e_ready});
    check($sformatf("%s enq", tag), {15'd0, e}, {15'd0, v.e_enq});
    if (v.cv) check($sformatf("%s value", tag), d, v.e_val);
    @(posedge CLK);
    #1;
  endtask

  initial begin
    // sel rstn flush valid data nf | ready enq cv value
    // Basic assembly (A)
    vq.push_back(mk(0, 0, 0, 0, 8'h00, 1, 1, 0, 1, 16'h0000));
    vq.push_back(mk(0, 1, 0, 1, 8'h34, 1, 1, 0, 0, 16'h0000));
    vq.push_back(mk(0, 1, 0, 1, 8'h12, 1, 1, 0, 0, 16'h0000));
    vq.push_back(mk(0, 1, 0, 0, 8'h00, 1, 1, 1, 1, 16'h1234));
    vq.push_back(mk(0, 1, 0, 0, 8'h00, 1, 1, 0, 0, 16'h0000));
    // Streaming 0x01..0x08
    vq.push_back(mk(0, 1, 0, 1, 8'h01, 1, 1, 0, 0, 16'h0000));
    vq.push_back(mk(0, 1, 0, 1, 8'h02, 1, 1, 0, 0, 16'h0000));
    vq.push_back(mk(0, 1, 0, 1, 8'h03, 1, 1, 1, 1, 16'h0201));
    vq.push_back(mk(0, 1, 0, 1, 8'h04, 1, 1, 0, 0, 16'h0000));
    vq.push_back(mk(0, 1, 0, 1, 8'h05, 1, 1, 1, 1, 16'h0403));
    vq.push_back(mk(0, 1, 0, 1, 8'h06, 1, 1, 0, 0, 16'h0000));
    vq.push_back(mk(0, 1, 0, 1, 8'h07, 1, 1, 1, 1, 16'h0605));
    vq.push_back(mk(0, 1, 0, 1, 8'h08, 1, 1, 0, 0, 16'h0000));
    vq.push_back(mk(0, 1, 0, 0, 8'h00, 1, 1, 1, 1, 16'h0807));
    vq.push_back(mk(0, 1, 0, 0, 8'h00, 1, 1, 0, 0, 16'h0000));
    // Backpressure: hold 0x2211, buffer 0x33, stall 0x44, then drain and accept together
    vq.push_back(mk(0, 1, 0, 1, 8'h11, 0, 1, 0, 0, 16'h0000));
    vq.push_back(mk(0, 1, 0, 1, 8'h22, 0, 1, 0, 0, 16'h0000));
    vq.push_back(mk(0, 1, 0, 1, 8'h33, 0, 1, 0, 1, 16'h2211));
    vq.push_back(mk(0, 1, 0, 1, 8'h44, 0, 0, 0, 1, 16'h2211));
    vq.push_back(mk(0, 1, 0, 1, 8'h44, 1, 1, 1, 1, 16'h2211));
    vq.push_back(mk(0, 1, 0, 0, 8'h00, 1, 1, 1, 1, 16'h4433));
    vq.push_back(mk(0, 1, 0, 0, 8'h00, 1, 1, 0, 0, 16'h0000));
    // FLUSH mid-token; flit offered during FLUSH is refused
    vq.push_back(mk(0, 1, 0, 1, 8'hAA, 1, 1, 0, 0, 16'h0000));
    vq.push_back(mk(0, 1, 1, 1, 8'h77, 1, 0, 0, 0, 16'h0000));
    vq.push_back(mk(0, 1, 0, 1, 8'h55, 1, 1, 0, 0, 16'h0000));
    vq.push_back(mk(0, 1, 0, 1, 8'h66, 1, 1, 0, 0, 16'h0000));
    vq.push_back(mk(0, 1, 0, 0, 8'h00, 1, 1, 1, 1, 16'h6655));
    vq.push_back(mk(0, 1, 0, 0, 8'h00, 1, 1, 0, 0, 16'h0000));
    // FLUSH discards a held token and masks ENQ in its own cycle
    vq.push_back(mk(0, 1, 0, 1, 8'h01, 0, 1, 0, 0, 16'h0000));
    vq.push_back(mk(0, 1, 0, 1, 8'h02, 0, 1, 0, 0, 16'h0000));
    vq.push_back(mk(0, 1, 0, 0, 8'h00, 0, 1, 0, 1, 16'h0201));
    vq.push_back(mk(0, 1, 1, 0, 8'h00, 1, 0, 0, 0, 16'h0000));
    vq.push_back(mk(0, 1, 0, 0, 8'h00, 1, 1, 0, 0, 16'h0000));
    // Padding (B): upper nibble of the final flit is dropped
    vq.push_back(mk(1, 0, 0, 0, 8'h00, 1, 1, 0, 1, 16'h0000));
    vq.push_back(mk(1, 1, 0, 1, 8'hAB, 1, 1, 0, 0, 16'h0000));
    vq.push_back(mk(1, 1, 0, 1, 8'hFC, 1, 1, 0, 0, 16'h0000));
    vq.push_back(mk(1, 1, 0, 0, 8'h00, 1, 1, 1, 1, 16'h0CAB));
    vq.push_back(mk(1, 1, 0, 0, 8'h00, 1, 1, 0, 0, 16'h0000));
    // NF=1 (C) with NOT_FULL toggling 1,0,1
    vq.push_back(mk(2, 0, 0, 0, 8'h00, 1, 1, 0, 1, 16'h0000));
    vq.push_back(mk(2, 1, 0, 1, 8'hA1, 1, 1, 0, 0, 16'h0000));
    vq.push_back(mk(2, 1, 0, 1, 8'hA2, 1, 1, 1, 1, 16'h00A1));
    vq.push_back(mk(2, 1, 0, 1, 8'hA3, 0, 0, 0, 1, 16'h00A2));
    vq.push_back(mk(2, 1, 0, 1, 8'hA3, 1, 1, 1, 1, 16'h00A2));
    vq.push_back(mk(2, 1, 0, 0, 8'h00, 1, 1, 1, 1, 16'h00A3));
    vq.push_back(mk(2, 1, 0, 0, 8'h00, 1, 1, 0, 0, 16'h0000));

    foreach (vq[i]) run_vec(vq[i], $sformatf("vec%0d", i));

    // Reset mid-token with a held token: async clear, then fresh assembly from flit 0
    run_vec(mk(0, 0, 0, 0, 8'h00, 1, 1, 0, 1, 16'h0000), "rst_pre");
    run_vec(mk(0, 1, 0, 1, 8'h01, 0, 1, 0, 0, 16'h0000), "rst_f0");
    run_vec(mk(0, 1, 0, 1, 8'h02, 0, 1, 0, 0, 16'h0000), "rst_f1");
    run_vec(mk(0, 1, 0, 1, 8'hAA, 0, 1, 0, 1, 16'h0201), "rst_partial");
    run_vec(mk(0, 0, 0, 0, 8'h00, 1, 1, 0, 1, 16'h0000), "rst_low0");
    run_vec(mk(0, 0, 0, 0, 8'h00, 1, 1, 0, 1, 16'h0000), "rst_low1");
    run_vec(mk(0, 1, 0, 1, 8'h55, 1, 1, 0, 0, 16'h0000), "rst_55");
    run_vec(mk(0, 1, 0, 1, 8'h66, 1, 1, 0, 0, 16'h0000), "rst_66");
    run_vec(mk(0, 1, 0, 0, 8'h00, 1, 1, 1, 1, 16'h6655), "rst_enq");
    run_vec(mk(0, 1, 0, 0, 8'h00, 1, 1, 0, 0, 16'h0000), "rst_idle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
